branch_hazard_ctrl: RTL and testbench

Sequencer for the ID-stage branch comparator of the 5-stage MIPS pipeline. Tracks in-flight register producers in EX/MEM/WB through internal shadow registers and stalls a branch in ID until both operands are available. Drives comparator operand forwarding selects and the PC-source select for a taken branch. Manages the one-instruction delay slot, optionally nullifying it for branch-likely.

---
 rtl/branch_hazard_ctrl_pkg.sv | 20 ++
 rtl/branch_hazard_ctrl_if.sv | 33 +++
 rtl/bh_hazard_check.sv | 32 +++
 rtl/branch_hazard_ctrl.sv | 102 ++++++++++
 tb/tb_branch_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared encodings and shadow-stage type for the ID-stage branch hazard sequencer.
package branch_hazard_ctrl_pkg;

  localparam logic [1:0] BH_IDLE = 2'd0;
  localparam logic [1:0] BH_WAIT = 2'd1;
  localparam logic [1:0] BH_SLOT = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       is_load;
  } bh_stage_t;

  localparam bh_stage_t BH_BUBBLE = '0;

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// ID-stage branch/producer inputs and hazard-control outputs of branch_hazard_ctrl.
interface branch_hazard_ctrl_if #(
  parameter int unsigned STALL_CNT_W = 32
);
  logic                   id_valid;
  logic                   id_we;
  logic [4:0]             id_dst;
  logic                   id_is_load;
  logic                   br_valid;
  logic                   br_uses_rt;
  logic [4:0]             br_rs;
  logic [4:0]             br_rt;
  logic                   br_taken;
  logic                   br_likely;
  logic                   stall;
  logic [1:0]             fwd_a;
  logic [1:0]             fwd_b;
  logic                   pc_sel;
  logic                   nullify;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_we, id_dst, id_is_load, br_valid, br_uses_rt, br_rs, br_rt,
           br_taken, br_likely,
    input  stall, fwd_a, fwd_b, pc_sel, nullify, stall_cycles
  );

  modport slave (
    input  id_valid, id_we, id_dst, id_is_load, br_valid, br_uses_rt, br_rs, br_rt,
           br_taken, br_likely,
    output stall, fwd_a, fwd_b, pc_sel, nullify, stall_cycles
  );
endinterface

// File: rtl/bh_hazard_check.sv
// Resolves one branch source register against the EX/MEM/WB shadows: stall or forward select.
module bh_hazard_check
  import branch_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  bh_stage_t  ex_i,
  input  bh_stage_t  mem_i,
  input  bh_stage_t  wb_i,
  output logic       hazard_o,
  output logic [1:0] fwd_o
);

  // An EX producer always stalls, so only the MEM load flag matters.
  logic unused_load;
  assign unused_load = ex_i.is_load ^ wb_i.is_load;

  always_comb begin
    hazard_o = 1'b0;
    fwd_o    = FWD_RF;
    if (src_i != 5'd0) begin
      if (ex_i.valid && ex_i.dst == src_i) begin
        hazard_o = 1'b1;
      end else if (mem_i.valid && mem_i.dst == src_i) begin
        if (mem_i.is_load) hazard_o = 1'b1;
        else               fwd_o    = FWD_MEM;
      end else if (wb_i.valid && wb_i.dst == src_i) begin
        fwd_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch sequencer: stalls on operand hazards, selects forwarding and PC source,
// steps through the delay slot. Define BRANCH_LIKELY_EN to nullify an untaken-likely slot.
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_hazard_ctrl_if.slave  bus
);

  logic [1:0]             state_q, state_d;
  bh_stage_t              ex_q, mem_q, wb_q, ex_d;
  logic [STALL_CNT_W-1:0] stall_cycles_q;
  logic                   haz_rs, haz_rt;
  logic [1:0]             fwd_rs, fwd_rt;
  logic                   active, hazard, resolve, stall, nullify;

  bh_hazard_check u_chk_rs (
    .src_i    (bus.br_rs),
    .ex_i     (ex_q),
    .mem_i    (mem_q),
    .wb_i     (wb_q),
    .hazard_o (haz_rs),
    .fwd_o    (fwd_rs)
  );

  bh_hazard_check u_chk_rt (
    .src_i    (bus.br_rt),
    .ex_i     (ex_q),
    .mem_i    (mem_q),
    .wb_i     (wb_q),
    .hazard_o (haz_rt),
    .fwd_o    (fwd_rt)
  );

  // Gated by reset so every output drops as soon as reset asserts.
  assign active  = !reset && ((state_q == BH_IDLE && bus.br_valid) || state_q == BH_WAIT);
  assign hazard  = haz_rs | (bus.br_uses_rt & haz_rt);
  assign resolve = active & ~hazard;
  assign stall   = active & hazard;

  assign bus.stall        = stall;
  assign bus.pc_sel       = resolve & bus.br_taken;
  assign bus.fwd_a        = active ? fwd_rs : FWD_RF;
  assign bus.fwd_b        = (active && bus.br_uses_rt) ? fwd_rt : FWD_RF;
  assign bus.nullify      = nullify;
  assign bus.stall_cycles = stall_cycles_q;

`ifdef BRANCH_LIKELY_EN
  logic nullify_q;
  assign nullify = nullify_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) nullify_q <= 1'b0;
    else       nullify_q <= resolve & bus.br_likely & ~bus.br_taken;
  end
`else
  logic unused_br_likely;
  assign unused_br_likely = bus.br_likely;
  assign nullify          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      BH_IDLE: if (bus.br_valid) state_d = hazard ? BH_WAIT : BH_SLOT;
      BH_WAIT: if (!hazard) state_d = BH_SLOT;
      BH_SLOT: state_d = BH_IDLE;
      default: state_d = BH_IDLE;
    endcase
  end

  always_comb begin
    if (stall || nullify || !bus.id_valid) begin
      ex_d = BH_BUBBLE;
    end else begin
      ex_d = '{valid: bus.id_we && (bus.id_dst != 5'd0), dst: bus.id_dst,
               is_load: bus.id_is_load};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= BH_IDLE;
      ex_q           <= BH_BUBBLE;
      mem_q          <= BH_BUBBLE;
      wb_q           <= BH_BUBBLE;
      stall_cycles_q <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      if (stall && stall_cycles_q != {STALL_CNT_W{1'b1}}) begin
        stall_cycles_q <= stall_cycles_q + STALL_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: directed pipeline scenarios plus random traffic
// against a producer-age model.
module tb_branch_hazard_ctrl;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_hazard_ctrl_if #(.STALL_CNT_W(W)) bus ();

  branch_hazard_ctrl #(.STALL_CNT_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Producers issued into the pipe, index = age (0: now in EX, 1: MEM, 2: WB).
  typedef struct {
    bit       v;
    bit [4:0] d;
    bit       ld;
  } prod_t;
  prod_t          hist[3];
  bit             m_wait, m_slot, m_null;
  logic [W-1:0]   m_cnt;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = '{v: 1'b0, d: 5'd0, ld: 1'b0};
    m_wait = 1'b0;
    m_slot = 1'b0;
    m_null = 1'b0;
    m_cnt  = '0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit iv, input bit we, input bit [4:0] dst, input bit ld,
                       input bit bv, input bit urt, input bit [4:0] rs, input bit [4:0] rt,
                       input bit tk, input bit lk);
    bus.id_valid   = iv;
    bus.id_we      = we;
    bus.id_dst     = dst;
    bus.id_is_load = ld;
    bus.br_valid   = bv;
    bus.br_uses_rt = urt;
    bus.br_rs      = rs;
    bus.br_rt      = rt;
    bus.br_taken   = tk;
    bus.br_likely  = lk;
    #1;
  endtask

  // Readiness by age: EX result not yet usable, MEM ALU result forwardable, MEM load not,
  // anything in WB forwardable. Youngest producer of the register decides.
  task automatic src_check(input bit [4:0] r, output bit haz, output bit [1:0] f);
    bit found = 1'b0;
    haz = 1'b0;
    f   = 2'b00;
    if (r != 5'd0) begin
      for (int a = 0; a < 3; a++) begin
        if (!found && hist[a].v && hist[a].d == r) begin
          found = 1'b1;
          if (a == 0 || (a == 1 && hist[a].ld)) haz = 1'b1;
          else f = (a == 1) ? 2'b01 : 2'b10;
        end
      end
    end
  endtask

  // Compare DUT against the model for the current inputs, then advance the model one clock.
  task automatic eval();
    bit       active, ha, hb, haz, res, e_stall, e_pc, e_null, issue;
    bit [1:0] fa, fb;
    prod_t    np;
    active = !m_slot && (m_wait || bus.br_valid);
    src_check(bus.br_rs, ha, fa);
    src_check(bus.br_rt, hb, fb);
    if (!bus.br_uses_rt) begin
      hb = 1'b0;
      fb = 2'b00;
    end
    haz     = ha | hb;
    res     = active && !haz;
    e_stall = active && haz;
    e_pc    = res && bus.br_taken;
`ifdef BRANCH_LIKELY_EN
    e_null  = m_null;
`else
    e_null  = 1'b0;
`endif
    chk("stall", bus.stall, e_stall);
    chk("fwd_a", bus.fwd_a, active ? fa : 2'b00);
    chk("fwd_b", bus.fwd_b, active ? fb : 2'b00);
    chk("pc_sel", bus.pc_sel, e_pc);
    chk("nullify", bus.nullify, e_null);
    chk("stall_cycles", bus.stall_cycles, m_cnt);

    issue = !(e_stall || e_null || !bus.id_valid);
    np.v  = issue && bus.id_we && bus.id_dst != 5'd0;
    np.d  = bus.id_dst;
    np.ld = bus.id_is_load;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = np;
    m_wait  = e_stall;
    m_slot  = res;
`ifdef BRANCH_LIKELY_EN
    m_null  = res && bus.br_likely && !bus.br_taken;
`else
    m_null  = 1'b0;
`endif
    if (e_stall && m_cnt != {W{1'b1}}) m_cnt = m_cnt + 1;
  endtask

  task automatic step(input bit iv, input bit we, input bit [4:0] dst, input bit ld,
                      input bit bv, input bit urt, input bit [4:0] rs, input bit [4:0] rt,
                      input bit tk, input bit lk);
    @(negedge clk);
    drive(iv, we, dst, ld, bv, urt, rs, rt, tk, lk);
    eval();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_fwd", {bus.fwd_a, bus.fwd_b}, 4'b0000);
    chk("rst_pc_sel", bus.pc_sel, 1'b0);
    chk("rst_nullify", bus.nullify, 1'b0);
    chk("rst_cnt", bus.stall_cycles, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    eval();
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    do_reset();

    // addu $3 ; beq $3,$4 taken: one stall, then MEM forward and pc_sel.
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 3, 4, 1, 0);
    chk("t1_stall", bus.stall, 1'b1);
    chk("t1_pc_hold", bus.pc_sel, 1'b0);
    step(1, 0, 0, 0, 1, 1, 3, 4, 1, 0);
    chk("t1_resolve_stall", bus.stall, 1'b0);
    chk("t1_fwd_a", bus.fwd_a, 2'b01);
    chk("t1_pc_sel", bus.pc_sel, 1'b1);
    step(1, 0, 0, 0, 1, 1, 3, 4, 1, 0);
    chk("t1_slot_pc", bus.pc_sel, 1'b0);
    chk("t1_slot_stall", bus.stall, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // lw $5 ; bne $5,$0: two stalls, then WB forward.
    do_reset();
    step(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 5, 0, 1, 0);
    chk("t2_stall1", bus.stall, 1'b1);
    step(1, 0, 0, 0, 1, 1, 5, 0, 1, 0);
    chk("t2_stall2", bus.stall, 1'b1);
    step(1, 0, 0, 0, 1, 1, 5, 0, 1, 0);
    chk("t2_stall3", bus.stall, 1'b0);
    chk("t2_fwd_a", bus.fwd_a, 2'b10);
    chk("t2_cnt", bus.stall_cycles, 2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // lw $5 ; nop ; bgtz $5 (rt=$5 unused): one stall, WB forward, fwd_b stays RF.
    step(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 5, 5, 0, 0);
    chk("t3_stall1", bus.stall, 1'b1);
    step(1, 0, 0, 0, 1, 0, 5, 5, 0, 0);
    chk("t3_stall2", bus.stall, 1'b0);
    chk("t3_fwd_a", bus.fwd_a, 2'b10);
    chk("t3_fwd_b", bus.fwd_b, 2'b00);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Producer of $0 ahead of beq $0,$0.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    chk("t4_stall", bus.stall, 1'b0);
    chk("t4_fwd", {bus.fwd_a, bus.fwd_b}, 4'b0000);
    chk("t4_pc_sel", bus.pc_sel, 1'b1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset during the second WAIT cycle of a load hazard.
    step(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 5, 0, 1, 0);
    step(1, 0, 0, 0, 1, 1, 5, 0, 1, 0);
    chk("t5_wait", bus.stall, 1'b1);
    reset = 1'b1;
    #1;
    chk("t5_rst_stall", bus.stall, 1'b0);
    chk("t5_rst_fwd", {bus.fwd_a, bus.fwd_b}, 4'b0000);
    chk("t5_rst_pc_sel", bus.pc_sel, 1'b0);
    chk("t5_rst_nullify", bus.nullify, 1'b0);
    chk("t5_rst_cnt", bus.stall_cycles, 0);
    model_reset();
    reset = 1'b0;
    #1;
    eval();
    chk("t5_no_stall", bus.stall, 1'b0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // beql $1,$2 not taken; the slot instruction writes $9; a branch on $9 follows.
    step(1, 0, 0, 0, 1, 1, 1, 2, 0, 1);
    chk("t6_pc_sel", bus.pc_sel, 1'b0);
    step(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
`ifdef BRANCH_LIKELY_EN
    chk("t6_nullify", bus.nullify, 1'b1);
`else
    chk("t6_nullify", bus.nullify, 1'b0);
`endif
    step(1, 0, 0, 0, 1, 1, 9, 0, 1, 0);
    chk("t6_next_nullify", bus.nullify, 1'b0);
`ifdef BRANCH_LIKELY_EN
    chk("t6_bubble", bus.stall, 1'b0);
`else
    chk("t6_bubble", bus.stall, 1'b1);
`endif

    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
